// File: rtl/bridge_pkg.sv
// +--------------------------------------------------------------------+
// | bridge_pkg : shared types and APB address map for the AHB-APB bridge |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package bridge_pkg;

  localparam int NSEL = 3;

  localparam logic [31:0] INTR_BASE  = 32'h8000_0000;
  localparam logic [31:0] TIMER_BASE = 32'h8400_0000;
  localparam logic [31:0] REMAP_BASE = 32'h8800_0000;
  localparam logic [31:0] MAP_END    = 32'h8C00_0000;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WWAIT    = 3'd1,
    ST_READ     = 3'd2,
    ST_WRITE    = 3'd3,
    ST_WRITEP   = 3'd4,
    ST_RENABLE  = 3'd5,
    ST_WENABLE  = 3'd6,
    ST_WENABLEP = 3'd7
  } state_t;

endpackage

`default_nettype wire

// File: rtl/apb_sel_decode.sv
// +--------------------------------------------------------------------+
// | apb_sel_decode : address -> one-hot APB slave select               |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module apb_sel_decode
  import bridge_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [NSEL-1:0]   sel
);

  always_comb begin
    sel = '0;
    if (addr >= ADDR_W'(INTR_BASE) && addr < ADDR_W'(TIMER_BASE))
      sel[0] = 1'b1;
    else if (addr >= ADDR_W'(TIMER_BASE) && addr < ADDR_W'(REMAP_BASE))
      sel[1] = 1'b1;
    else if (addr >= ADDR_W'(REMAP_BASE) && addr < ADDR_W'(MAP_END))
      sel[2] = 1'b1;
  end

endmodule

`default_nettype wire

// File: rtl/ahb_apb_fsm_controller.sv
// +--------------------------------------------------------------------+
// | ahb_apb_fsm_controller : APB SETUP/ENABLE sequencer of the bridge   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module ahb_apb_fsm_controller
  import bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NSEL   = 3
) (
  input  logic              Hclk,
  input  logic              Hreset,
  input  logic              valid,
  input  logic              Hwrite,
  input  logic              Hwrite_reg,
  input  logic [ADDR_W-1:0] Haddr,
  input  logic [ADDR_W-1:0] Haddr1,
  input  logic [ADDR_W-1:0] Haddr2,
  input  logic [DATA_W-1:0] Hwdata,
  input  logic [DATA_W-1:0] Hwdata1,
  output logic              Pwrite,
  output logic              Penable,
  output logic [NSEL-1:0]   Pselx,
  output logic [ADDR_W-1:0] Paddr,
  output logic [DATA_W-1:0] Pwdata,
  output logic              Hreadyout
);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] w_paddr_nxt;
  logic [DATA_W-1:0] w_pwdata_nxt;
  logic [NSEL-1:0]   w_sel;

  always_comb begin
    w_next = ST_IDLE;
    case (r_state)
      ST_IDLE, ST_RENABLE, ST_WENABLE:
        if (valid) w_next = Hwrite ? ST_WWAIT : ST_READ;
      ST_WWAIT:    w_next = valid ? ST_WRITEP : ST_WRITE;
      ST_READ:     w_next = ST_RENABLE;
      ST_WRITE:    w_next = valid ? ST_WENABLEP : ST_WENABLE;
      ST_WRITEP:   w_next = ST_WENABLEP;
      ST_WENABLEP: begin
        if (!Hwrite_reg) w_next = ST_READ;
        else             w_next = valid ? ST_WRITEP : ST_WRITE;
      end
      default:     w_next = ST_IDLE;
    endcase
  end

  // Outputs track the state being entered, so the bus fields are muxed on w_next.
  always_comb begin
    w_paddr_nxt  = Paddr;
    w_pwdata_nxt = Pwdata;
    case (w_next)
      ST_READ:   w_paddr_nxt = Haddr;
      ST_WRITE: begin
        w_paddr_nxt  = Haddr1;
        w_pwdata_nxt = Hwdata;
      end
      ST_WRITEP: begin
        w_paddr_nxt  = Haddr2;
        w_pwdata_nxt = Hwdata1;
      end
      default: ;
    endcase
  end

  apb_sel_decode #(
    .ADDR_W (ADDR_W)
  ) u_sel_decode (
    .addr (w_paddr_nxt),
    .sel  (w_sel)
  );

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      r_state   <= ST_IDLE;
      Pwrite    <= 1'b0;
      Penable   <= 1'b0;
      Pselx     <= '0;
      Paddr     <= '0;
      Pwdata    <= '0;
      Hreadyout <= 1'b1;
    end else begin
      r_state <= w_next;
      Paddr   <= w_paddr_nxt;
      Pwdata  <= w_pwdata_nxt;
      case (w_next)
        ST_READ: begin
          Pselx     <= w_sel;
          Pwrite    <= 1'b0;
          Penable   <= 1'b0;
          Hreadyout <= 1'b0;
        end
        ST_WRITE, ST_WRITEP: begin
          Pselx     <= w_sel;
          Pwrite    <= 1'b1;
          Penable   <= 1'b0;
          Hreadyout <= 1'b0;
        end
        ST_RENABLE, ST_WENABLE: begin
          Penable   <= 1'b1;
          Hreadyout <= 1'b1;
        end
        ST_WENABLEP: begin
          Penable   <= 1'b1;
          Hreadyout <= 1'b0;
        end
        default: begin
          Pselx     <= '0;
          Penable   <= 1'b0;
          Hreadyout <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ahb_apb_fsm_controller.sv
// +--------------------------------------------------------------------+
// | tb_ahb_apb_fsm_controller : scoreboard bench for the APB sequencer  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_ahb_apb_fsm_controller;
  import bridge_pkg::*;

  logic        Hclk = 1'b0;
  logic        Hreset = 1'b1;
  logic        valid = 1'b0;
  logic        Hwrite = 1'b0;
  logic        Hwrite_reg = 1'b0;
  logic [31:0] Haddr = '0;
  logic [31:0] Haddr1 = '0;
  logic [31:0] Haddr2 = '0;
  logic [31:0] Hwdata = '0;
  logic [31:0] Hwdata1 = '0;
  logic        Pwrite, Penable, Hreadyout;
  logic [2:0]  Pselx;
  logic [31:0] Paddr, Pwdata;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        wr;
    logic [2:0]  sel;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 Hclk = ~Hclk;

  ahb_apb_fsm_controller #(
    .ADDR_W (32),
    .DATA_W (32),
    .NSEL   (3)
  ) dut (
    .Hclk       (Hclk),
    .Hreset     (Hreset),
    .valid      (valid),
    .Hwrite     (Hwrite),
    .Hwrite_reg (Hwrite_reg),
    .Haddr      (Haddr),
    .Haddr1     (Haddr1),
    .Haddr2     (Haddr2),
    .Hwdata     (Hwdata),
    .Hwdata1    (Hwdata1),
    .Pwrite     (Pwrite),
    .Penable    (Penable),
    .Pselx      (Pselx),
    .Paddr      (Paddr),
    .Pwdata     (Pwdata),
    .Hreadyout  (Hreadyout)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle: shift the upstream pipeline copies, drive new values, sample after the edge.
  task automatic step(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge Hclk);
    Haddr2     = Haddr1;
    Haddr1     = Haddr;
    Hwdata1    = Hwdata;
    Hwrite_reg = Hwrite;
    valid      = v;
    Hwrite     = w;
    Haddr      = a;
    Hwdata     = d;
    @(posedge Hclk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic wr, input logic [2:0] sel);
    exp_t e;
    e.addr = a; e.data = d; e.wr = wr; e.sel = sel;
    q.push_back(e);
  endtask

  // Monitor: every ENABLE phase is one completed APB access.
  initial begin : monitor
    logic [2:0] prev_sel;
    logic       prev_en;
    exp_t       e;
    prev_sel = '0;
    prev_en  = 1'b0;
    forever begin
      @(posedge Hclk);
      #1;
      if (Penable) begin
        chk("setup_precedes_enable", {60'd0, prev_en, prev_sel}, {60'd0, 1'b0, Pselx});
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_access: got addr %0h with nothing expected", Paddr);
        end else begin
          e = q.pop_front();
          chk("apb_addr", Paddr, e.addr);
          chk("apb_write", Pwrite, e.wr);
          chk("apb_sel", Pselx, e.sel);
          if (e.wr) chk("apb_wdata", Pwdata, e.data);
        end
      end
      prev_sel = Pselx;
      prev_en  = Penable;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin : stim
    step(0, 0, 32'h0, 32'h0);
    step(0, 0, 32'h0, 32'h0);
    chk("rst_penable", Penable, 0);
    chk("rst_pselx", Pselx, 0);
    chk("rst_hreadyout", Hreadyout, 1);
    chk("rst_paddr", Paddr, 0);
    Hreset = 1'b0;

    // Single read of the timer region
    push(32'h8400_0010, 32'h0, 1'b0, 3'b010);
    step(1, 0, 32'h8400_0010, 32'h0);
    chk("rd_setup_pselx", Pselx, 3'b010);
    chk("rd_setup_paddr", Paddr, 32'h8400_0010);
    chk("rd_setup_pwrite", Pwrite, 0);
    chk("rd_setup_penable", Penable, 0);
    chk("rd_setup_hready", Hreadyout, 0);
    step(0, 0, 32'h0, 32'h0);
    chk("rd_enable_penable", Penable, 1);
    chk("rd_enable_hready", Hreadyout, 1);
    step(0, 0, 32'h0, 32'h0);
    chk("rd_after_pselx", Pselx, 0);

    // Single write, then reset in the middle of its ENABLE phase
    push(32'h8000_0004, 32'hDEAD_BEEF, 1'b1, 3'b001);
    step(1, 1, 32'h8000_0004, 32'h0);
    chk("wr_wwait_pselx", Pselx, 0);
    chk("wr_wwait_hready", Hreadyout, 1);
    step(0, 0, 32'h0, 32'hDEAD_BEEF);
    chk("wr_setup_paddr", Paddr, 32'h8000_0004);
    chk("wr_setup_pwdata", Pwdata, 32'hDEAD_BEEF);
    chk("wr_setup_pselx", Pselx, 3'b001);
    chk("wr_setup_pwrite", Pwrite, 1);
    chk("wr_setup_hready", Hreadyout, 0);
    step(0, 0, 32'h0, 32'h0);
    chk("wr_enable_penable", Penable, 1);
    chk("wr_enable_hready", Hreadyout, 1);
    Hreset = 1'b1;
    step(0, 0, 32'h0, 32'h0);
    chk("midrst_penable", Penable, 0);
    chk("midrst_pselx", Pselx, 0);
    chk("midrst_paddr", Paddr, 0);
    chk("midrst_pwdata", Pwdata, 0);
    chk("midrst_hready", Hreadyout, 1);
    chk("midrst_state", dut.r_state, ST_IDLE);
    step(0, 0, 32'h0, 32'h0);
    Hreset = 1'b0;

    // Back-to-back writes to the remap region
    push(32'h8800_0000, 32'h11, 1'b1, 3'b100);
    push(32'h8800_0004, 32'h22, 1'b1, 3'b100);
    push(32'h8800_0008, 32'h33, 1'b1, 3'b100);
    step(0, 0, 32'h8800_0000, 32'h0);
    step(1, 1, 32'h8800_0000, 32'h11);
    chk("b2b_wwait_hready", Hreadyout, 1);
    step(1, 1, 32'h8800_0004, 32'h11);
    chk("b2b_writep1_hready", Hreadyout, 0);
    chk("b2b_writep1_paddr", Paddr, 32'h8800_0000);
    step(0, 1, 32'h8800_0004, 32'h22);
    chk("b2b_wenablep1_hready", Hreadyout, 0);
    step(1, 1, 32'h8800_0008, 32'h22);
    chk("b2b_writep2_hready", Hreadyout, 0);
    chk("b2b_writep2_pwdata", Pwdata, 32'h22);
    step(0, 1, 32'h8800_0008, 32'h22);
    chk("b2b_wenablep2_hready", Hreadyout, 0);
    step(0, 0, 32'h8800_0008, 32'h33);
    chk("b2b_write3_penable", Penable, 0);
    step(0, 0, 32'h0, 32'h33);
    chk("b2b_wenable3_hready", Hreadyout, 1);
    step(0, 0, 32'h0, 32'h0);
    chk("b2b_idle_pselx", Pselx, 0);

    // Write immediately followed by a read
    push(32'h8400_0000, 32'hAAAA_5555, 1'b1, 3'b010);
    push(32'h8000_0008, 32'h0, 1'b0, 3'b001);
    step(0, 0, 32'h8400_0000, 32'h0);
    step(1, 1, 32'h8400_0000, 32'hAAAA_5555);
    step(1, 0, 32'h8000_0008, 32'hAAAA_5555);
    chk("wr_rd_writep_paddr", Paddr, 32'h8400_0000);
    step(0, 0, 32'h8000_0008, 32'h0);
    step(0, 0, 32'h8000_0008, 32'h0);
    chk("wr_rd_read_paddr", Paddr, 32'h8000_0008);
    chk("wr_rd_read_pwrite", Pwrite, 0);
    chk("wr_rd_read_pselx", Pselx, 3'b001);
    step(0, 0, 32'h0, 32'h0);

    // Idle hold: bus fields keep the last access
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 32'h0, 32'h0);
      chk("idle_pselx", Pselx, 0);
      chk("idle_penable", Penable, 0);
      chk("idle_hready", Hreadyout, 1);
      chk("idle_paddr", Paddr, 32'h8000_0008);
      chk("idle_pwdata", Pwdata, 32'hAAAA_5555);
    end

    // Unmapped read still sequences, with no select
    push(32'h1000_0000, 32'h0, 1'b0, 3'b000);
    step(1, 0, 32'h1000_0000, 32'h0);
    chk("unmapped_pselx", Pselx, 0);
    chk("unmapped_hready", Hreadyout, 0);
    step(0, 0, 32'h0, 32'h0);
    step(0, 0, 32'h0, 32'h0);
    step(0, 0, 32'h0, 32'h0);

    chk("scoreboard_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ahb_apb_fsm_controller.md
Name: ahb_apb_fsm_controller

Overview:
- Downstream stage of the AHB slave interface inside the AHB-to-APB bridge.
- Consumes the decoded transfer qualifier (valid), the pipelined address/data copies and the registered write flag.
- Sequences APB SETUP/ENABLE phases and drives Pselx, Paddr, Pwdata, Pwrite and Penable.
- Stalls the AHB side through Hreadyout.
- Supports back-to-back (pipelined) AHB writes without losing a beat.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- NSEL, 3, number of APB slave selects (interrupt, counter_timer, remap).

Ports:
- Hclk  in  1  bridge clock.
- Hreset  in  1  synchronous active-high reset.
- valid  in  1  qualified AHB NONSEQ/SEQ transfer to the bridge map this cycle.
- Hwrite  in  1  current-cycle AHB write flag.
- Hwrite_reg  in  1  Hwrite delayed one Hclk.
- Haddr  in  ADDR_W  current AHB address.
- Haddr1  in  ADDR_W  Haddr delayed 1 cycle.
- Haddr2  in  ADDR_W  Haddr delayed 2 cycles.
- Hwdata  in  DATA_W  current AHB write data.
- Hwdata1  in  DATA_W  Hwdata delayed 1 cycle.
- Pwrite  out  1  APB direction.
- Penable  out  1  APB ENABLE phase.
- Pselx  out  NSEL  one-hot APB slave select.
- Paddr  out  ADDR_W  APB address.
- Pwdata  out  DATA_W  APB write data.
- Hreadyout  out  1  bridge ready to AHB (0 = wait state).

Behaviour:
- All outputs are registered. Each output value is computed from the next state, so it changes on the same Hclk edge the state enters.
- Reset (Hreset=1 at a posedge) applies the following, regardless of state, including mid-transfer; the aborted APB access is simply dropped:
  - state=ST_IDLE.
  - Pwrite=0, Penable=0, Pselx=0, Paddr=0, Pwdata=0, Hreadyout=1.
- Pselx decode from the address driven onto Paddr, with the map constants taken from the package:
  - [8000_0000, 8400_0000) -> 001.
  - [8400_0000, 8800_0000) -> 010.
  - [8800_0000, 8C00_0000) -> 100.
  - Otherwise 000.
- States, listing (outputs on entry) and transitions:
  - ST_IDLE: Psel=0, Penable=0, Hreadyout=1.
    - valid&!Hwrite -> ST_READ.
    - valid&Hwrite -> ST_WWAIT.
    - Otherwise stay.
  - ST_WWAIT: Psel=0, Hreadyout=1; waits for the write data phase.
    - valid -> ST_WRITEP.
    - Otherwise -> ST_WRITE.
  - ST_READ (SETUP): Paddr=Haddr, Pselx=decode(Haddr), Pwrite=0, Penable=0, Hreadyout=0.
    - Always -> ST_RENABLE.
  - ST_WRITE (SETUP, single): Paddr=Haddr1, Pwdata=Hwdata, Pwrite=1, Penable=0, Hreadyout=0.
    - valid -> ST_WENABLEP.
    - Otherwise -> ST_WENABLE.
  - ST_WRITEP (SETUP, pipelined): Paddr=Haddr2, Pwdata=Hwdata1, Pwrite=1, Penable=0, Hreadyout=0.
    - Always -> ST_WENABLEP.
  - ST_RENABLE / ST_WENABLE: Penable=1; Paddr, Pwdata, Pwrite, Pselx held; Hreadyout=1.
    - Next state by the same rule as ST_IDLE.
  - ST_WENABLEP: Penable=1; bus signals held; Hreadyout=0.
    - !Hwrite_reg -> ST_READ.
    - valid&Hwrite_reg -> ST_WRITEP.
    - !valid&Hwrite_reg -> ST_WRITE.
- Every APB access is exactly 2 Hclk: SETUP then ENABLE. No PREADY support; APB slaves are zero-wait.
- Latency:
  - Read: valid -> Psel asserted next edge; Hreadyout low 1 cycle.
  - Single write: Psel asserted 2 edges after valid (the WWAIT cycle collects Hwdata).
- Pselx must never be non-zero while Penable=1 without having been non-zero in the preceding cycle.
- Unmapped address with valid=1: cannot occur, because valid is pre-qualified. If it does occur, the FSM still sequences normally with Pselx=000.
- Paddr/Pwdata keep their last value in ST_IDLE and ST_WWAIT; only Pselx/Penable are cleared.

Decomposition:
- Package bridge_pkg holds:
  - State enum: ST_IDLE, ST_WWAIT, ST_READ, ST_WRITE, ST_WRITEP, ST_RENABLE, ST_WENABLE, ST_WENABLEP.
  - Address-map constants: INTR_BASE=8000_0000, TIMER_BASE=8400_0000, REMAP_BASE=8800_0000, MAP_END=8C00_0000.
  - NSEL.
- One sub-module: apb_sel_decode, a combinational address -> one-hot Pselx decoder, instantiated once on the muxed next-Paddr.

Test Plan:
- Reset:
  - Stimulus: assert Hreset for 2 cycles mid-ST_WENABLE.
  - Required: next edge Penable=0, Pselx=000, Paddr=0, Pwdata=0, Hreadyout=1, state=ST_IDLE.
- Single read:
  - Stimulus: valid=1, Hwrite=0, Haddr=8400_0010 for 1 cycle.
  - Required:
    - Cycle+1: Pselx=010, Paddr=8400_0010, Pwrite=0, Penable=0, Hreadyout=0.
    - Cycle+2: Penable=1, Hreadyout=1.
    - Cycle+3: Pselx=000.
- Single write:
  - Stimulus: valid=1, Hwrite=1, Haddr=8000_0004, then Hwdata=DEAD_BEEF with valid=0.
  - Required:
    - ST_WWAIT, then SETUP with Paddr=8000_0004, Pwdata=DEAD_BEEF, Pselx=001, Pwrite=1.
    - Then ENABLE with Penable=1, Hreadyout=1.
- Back-to-back writes:
  - Stimulus: 3 consecutive writes to 8800_0000/04/08 with data 11/22/33.
  - Required: three APB accesses in order with Pselx=100, each Paddr paired with its own data. Hreadyout low during each WRITEP/WENABLEP; no beat lost or duplicated.
- Write followed by read:
  - Stimulus: write 8400_0000=AAAA_5555, then immediate read of 8000_0008.
  - Required: write ENABLE completes, then ST_READ with Paddr=8000_0008, Pwrite=0, Pselx=001.
- Idle hold:
  - Stimulus: valid=0 for 10 cycles after a transfer.
  - Required: Pselx=000, Penable=0, Hreadyout=1; Paddr/Pwdata unchanged.
